// File: rtl/shift_pkg.sv
// Shared definitions for the sequenced shifter and its single-step stage:
// operation encodings, FSM state encodings and the per-cycle shift limit.
package shift_pkg;

  // Largest shift one pass through the step stage can apply (2-bit amount)
  localparam int STEP_MAX = 3;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step8.sv
// Combinational single-step shifter: shifts data by s (0..3) according to op.
// All four candidate shifts are formed and a 4:1 mux on s picks one, so the
// same cell serves the single-step shift stage and the sequenced shifter.
// Optional feature macro: SHIFT_SEQ_ROT_EN enables rotate-right for OP_ROR;
// without it OP_ROR passes the data through unchanged.
module shift_step8
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       s,
  input  op_e              op,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0]   cand [4];
  logic [2*WIDTH-1:0] rot;

  // Build the four shift candidates for the selected op, then mux on s
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cand[i] = data;
    end
    rot = '0;
    for (int i = 0; i < 4; i++) begin
      case (op)
        OP_LSL: cand[i] = data << i;
        OP_LSR: cand[i] = data >> i;
        OP_ASR: cand[i] = $signed(data) >>> i;
        OP_ROR: begin
`ifdef SHIFT_SEQ_ROT_EN
          rot     = {data, data} >> i;
          cand[i] = rot[WIDTH-1:0];
`else
          cand[i] = data;
`endif
        end
        default: cand[i] = data;
      endcase
    end
    result = cand[s];
  end

endmodule

// File: rtl/shift_seq8.sv
// Multi-cycle sequenced shifter. Accepts a full shift amount and applies it
// through the single-step stage at most STEP_MAX bits per clock, feeding the
// result back until the amount is used up. start/busy/done handshake, one
// request in flight; d_out holds until the next start is accepted.
// Optional feature macro: SHIFT_SEQ_ROT_EN (rotate-right for op=11, handled
// inside shift_step8).
module shift_seq8
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             busy,
  output logic             done
);

  state_e           state, next_state;
  op_e              op_q;
  logic [AMT_W-1:0] rem, rem_next;
  logic [1:0]       step;
  logic [WIDTH-1:0] step_out;

  // Step size this cycle is min(rem, STEP_MAX); rem never underflows
  always_comb begin
    step     = 2'(STEP_MAX);
    if (rem <= AMT_W'(STEP_MAX)) begin
      step = rem[1:0];
    end
    rem_next = rem - AMT_W'(step);
  end

  shift_step8 #(.WIDTH(WIDTH)) u_step (
    .data   (d_out),
    .s      (step),
    .op     (op_q),
    .result (step_out)
  );

  // Next-state logic and handshake outputs
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (rem_next == '0) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State, request latch, remaining-amount counter and result register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      op_q  <= OP_LSL;
      rem   <= '0;
      d_out <= '0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op_e'(op);
            rem   <= amt;
            d_out <= d_in;
          end
        end
        ST_SHIFT: begin
          d_out <= step_out;
          rem   <= rem_next;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq8.sv
// Self-checking bench for shift_seq8: directed cases, start held high,
// reset mid-shift, an exhaustive op x amt x d_in sweep and random requests.
// Expected results come from a whole-amount reference model; a monitor pops
// them from a scoreboard whenever done is seen.
// Optional feature macro: SHIFT_SEQ_ROT_EN (selects ROR expectations).
`timescale 1ns/1ps
module tb_shift_seq8;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [2:0] amt = 3'd0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] result;
    int         done_edge;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_count = 0;
  logic prev_done = 1'b0;

  shift_seq8 #(.WIDTH(8), .AMT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .amt     (amt),
    .d_in    (d_in),
    .d_out   (d_out),
    .busy    (busy),
    .done    (done)
  );

  // 10 ns clock
  initial forever #5 clk = ~clk;

  // Count rising edges for latency checks
  always @(posedge clk) edge_count <= edge_count + 1;

  // Reference: apply the whole amount in one go
  function automatic logic [7:0] model(input logic [1:0] o, input logic [2:0] a,
                                       input logic [7:0] d);
    logic [15:0] t;
    case (o)
      2'b00: return d << a;
      2'b01: return d >> a;
      2'b10: return $signed(d) >>> a;
      default: begin
`ifdef SHIFT_SEQ_ROT_EN
        t = {d, d} >> a;
        return t[7:0];
`else
        t = 16'h0;
        return d;
`endif
      end
    endcase
  endfunction

  // Shift cycles needed: max(1, ceil(amt/3))
  function automatic int latency(input logic [2:0] a);
    if (a == 3'd0) return 1;
    return (int'(a) + 2) / 3;
  endfunction

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic wait_idle();
    int waited = 0;
    @(negedge clk);
    while (busy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_timeout: busy still 1 after %0d cycles", waited);
    end
  endtask

  // Issue one request at an idle cycle and push its expectation
  task automatic apply_stimulus(input logic [1:0] o, input logic [2:0] a,
                                input logic [7:0] d, input logic [7:0] expv);
    exp_t e;
    wait_idle();
    op      = o;
    amt     = a;
    d_in    = d;
    start   = 1'b1;
    e.result    = expv;
    e.done_edge = edge_count + 1 + latency(a);
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    amt   = 3'($urandom);
    d_in  = 8'($urandom);
  endtask

  // Monitor: compare result and latency on done, check done is one cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_done) begin
        check_output("done_pulse_busy", {14'h0, done, busy}, 16'h0);
      end
      prev_done = done;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done: d_out=%0h with no request pending", d_out);
        end else begin
          e = sb.pop_front();
          check_output("result", {8'h0, d_out}, {8'h0, e.result});
          check_output("done_edge", 16'(edge_count), 16'(e.done_edge));
        end
      end
    end
  end

  initial begin
    int accepted;
    int guard;
    exp_t e;
    logic [2:0] ra;
    logic [1:0] ro;
    logic [7:0] rd;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_d_out", {8'h0, d_out}, 16'h0);
    check_output("reset_busy", {15'h0, busy}, 16'h0);
    check_output("reset_done", {15'h0, done}, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset mid-shift: request is lost, no done pulse
    wait_idle();
    op = 2'b00; amt = 3'd7; d_in = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_output("midreset_d_out", {8'h0, d_out}, 16'h0);
    check_output("midreset_busy", {15'h0, busy}, 16'h0);
    check_output("midreset_done", {15'h0, done}, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed cases with known answers
    apply_stimulus(2'b00, 3'd5, 8'hB5, 8'hA0);
    apply_stimulus(2'b10, 3'd7, 8'h90, 8'hFF);
    apply_stimulus(2'b01, 3'd4, 8'h90, 8'h09);
    apply_stimulus(2'b00, 3'd0, 8'h5A, 8'h5A);
`ifdef SHIFT_SEQ_ROT_EN
    apply_stimulus(2'b11, 3'd1, 8'h81, 8'hC0);
    apply_stimulus(2'b11, 3'd7, 8'h81, 8'h03);
`else
    apply_stimulus(2'b11, 3'd1, 8'h81, 8'h81);
    apply_stimulus(2'b11, 3'd7, 8'h81, 8'h81);
`endif

    // start held high: inputs churn while busy, only idle-cycle values count
    wait_idle();
    start = 1'b1;
    accepted = 0;
    guard = 0;
    while (accepted < 4 && guard < 200) begin
      if (!busy) begin
        if (accepted == 0) begin
          op = 2'b00; amt = 3'd3; d_in = 8'h01;
          e.result = 8'h08;
        end else begin
          op = 2'($urandom); amt = 3'($urandom); d_in = 8'($urandom);
          e.result = model(op, amt, d_in);
        end
        e.done_edge = edge_count + 1 + latency(amt);
        sb.push_back(e);
        accepted++;
      end else begin
        op = 2'($urandom); amt = 3'($urandom); d_in = 8'($urandom);
      end
      if (accepted < 4) begin
        @(negedge clk);
        guard++;
      end
    end
    @(posedge clk);
    #1 start = 1'b0;
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL held_start_timeout: accepted %0d of 4", accepted);
    end

    // Exhaustive sweep
    for (int o = 0; o < 4; o++) begin
      for (int a = 0; a < 8; a++) begin
        for (int d = 0; d < 256; d++) begin
          apply_stimulus(2'(o), 3'(a), 8'(d), model(2'(o), 3'(a), 8'(d)));
        end
      end
    end

    // Random requests with random idle gaps
    for (int i = 0; i < 300; i++) begin
      ro = 2'($urandom);
      ra = 3'($urandom);
      rd = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      apply_stimulus(ro, ra, rd, model(ro, ra, rd));
    end

    // Drain the scoreboard
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: %0d results never arrived", sb.size());
    end
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
